// File: rtl/npc_lsu_pkg.sv
// npc load/store unit shared types.
// Access size, error code and FSM state encodings.
package npc_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MREQ  = 2'd1,
    S_MWAIT = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/npc_lsu_align.sv
// npc LSU byte-lane logic: alignment check, store lane
// placement and load extraction with sign/zero extension.
module npc_lsu_align
  import npc_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFS_W  = $clog2(DATA_W / 8)
) (
  input  size_e              chk_size,
  input  logic [OFS_W-1:0]   chk_ofs,
  output logic               misalign,
  input  size_e              size,
  input  logic [OFS_W-1:0]   ofs,
  input  logic               is_unsigned,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DATA_W-1:0]  rdata,
  output logic [DATA_W/8-1:0] wmask,
  output logic [DATA_W-1:0]  wdata_sh,
  output logic [DATA_W-1:0]  rdata_ext
);

  localparam int MW = DATA_W / 8;

  logic [7:0]        base;
  logic [DATA_W-1:0] sh;

  // dword is only legal on a 64-bit port
  always_comb begin
    misalign = 1'b0;
    unique case (1'b1)
      (chk_size == SZ_H): misalign = chk_ofs[0];
      (chk_size == SZ_W): misalign = |chk_ofs[1:0];
      (chk_size == SZ_D): misalign = (DATA_W == 32) || (|chk_ofs);
      default:            misalign = 1'b0;
    endcase
  end

  always_comb begin
    base = 8'h01;
    unique case (size)
      SZ_B: base = 8'h01;
      SZ_H: base = 8'h03;
      SZ_W: base = 8'h0f;
      SZ_D: base = 8'hff;
    endcase
  end

  assign wmask    = MW'(base) << ofs;
  assign wdata_sh = wdata << {ofs, 3'b000};
  assign sh       = rdata >> {ofs, 3'b000};

  always_comb begin
    rdata_ext = sh;
    unique case (size)
      SZ_B: rdata_ext = is_unsigned ? DATA_W'(sh[7:0])
                                    : DATA_W'($signed(sh[7:0]));
      SZ_H: rdata_ext = is_unsigned ? DATA_W'(sh[15:0])
                                    : DATA_W'($signed(sh[15:0]));
      SZ_W: rdata_ext = is_unsigned ? DATA_W'(sh[31:0])
                                    : DATA_W'($signed(sh[31:0]));
      SZ_D: rdata_ext = sh;
    endcase
  end

endmodule

// File: rtl/npc_lsu.sv
// npc multi-cycle load/store unit: one request at a time,
// variable-latency memory port with misalign and timeout errors.
module npc_lsu
  import npc_lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [4:0]          req_rd,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [4:0]          resp_rd,
  output logic [1:0]          resp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MW    = DATA_W / 8;
  localparam int OFS_W = $clog2(MW);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  state_e              state_q, state_d;
  logic                wen_q, uns_q;
  size_e               size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [4:0]          rd_q;
  err_e                err_q;
  logic [TW-1:0]       cnt_q;

  logic                accept, misalign, cap, tmo, limit, busy_q, busy_d;
  logic [MW-1:0]       wmask;
  logic [DATA_W-1:0]   wdata_sh, rdata_ext;

  npc_lsu_align #(
    .DATA_W (DATA_W),
    .OFS_W  (OFS_W)
  ) u_align (
    .chk_size    (size_e'(req_size)),
    .chk_ofs     (req_addr[OFS_W-1:0]),
    .misalign    (misalign),
    .size        (size_q),
    .ofs         (addr_q[OFS_W-1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata       (mem_rdata),
    .wmask       (wmask),
    .wdata_sh    (wdata_sh),
    .rdata_ext   (rdata_ext)
  );

  assign accept = (state_q == S_IDLE) && req_valid;
  assign limit  = cnt_q >= TW'(TIMEOUT_CYC - 1);
  assign busy_q = (state_q == S_MREQ) || (state_q == S_MWAIT);
  assign busy_d = (state_d == S_MREQ) || (state_d == S_MWAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = misalign ? S_RESP : S_MREQ;
      end
      S_MREQ: begin
        if (mem_ready) begin
          if (wen_q) begin
            state_d = S_RESP;
          end else if (mem_rvalid) begin
            state_d = S_RESP;
            cap     = 1'b1;
          end else begin
            state_d = S_MWAIT;
          end
        end else if (limit) begin
          state_d = S_RESP;
          tmo     = 1'b1;
        end
      end
      S_MWAIT: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
          cap     = 1'b1;
        end else if (limit) begin
          state_d = S_RESP;
          tmo     = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= ERR_OK;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        wen_q   <= req_wen;
        uns_q   <= req_unsigned;
        size_q  <= size_e'(req_size);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
        err_q   <= misalign ? ERR_MISALIGN : ERR_OK;
        rdata_q <= '0;
      end
      if (cap) rdata_q <= rdata_ext;
      if (tmo) err_q   <= ERR_TIMEOUT;
      if (busy_q && busy_d) cnt_q <= cnt_q + 1'b1;
      else                  cnt_q <= '0;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign mem_valid  = (state_q == S_MREQ);
  assign mem_wen    = mem_valid && wen_q;
  assign mem_addr   = mem_valid ? {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}} : '0;
  assign mem_wdata  = mem_wen ? wdata_sh : '0;
  assign mem_wmask  = mem_wen ? wmask : '0;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_rd    = resp_valid ? rd_q : '0;
  assign resp_err   = resp_valid ? err_q : ERR_OK;

endmodule

// File: tb/tb_npc_lsu.sv
// Self-checking bench for npc_lsu: scoreboarded responses
// plus per-scenario timing, lane and reset checks.
module tb_npc_lsu;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [1:0]  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  npc_lsu #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_rd      (resp_rd),
    .resp_err     (resp_err),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  // scoreboard: every completed response handshake pops one entry
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      exp_t got, e;
      got = {resp_rdata, resp_rd, resp_err};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got=%h required=none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL resp got rdata=%h rd=%0d err=%0d required rdata=%h rd=%0d err=%0d",
                   resp_rdata, resp_rd, resp_err, e.rdata, e.rd, e.err);
        end
      end
    end
  end

  task automatic mem_set(input logic rdy, input logic rv,
                         input logic [31:0] d);
    mem_ready  = rdy;
    mem_rvalid = rv;
    mem_rdata  = d;
  endtask

  task automatic issue(input logic wen, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_wen      = wen;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    req_rd       = rd;
    req_valid    = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got=%b required=1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready && !resp_valid) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle got=busy required=idle");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if ({req_ready, mem_valid, resp_valid, mem_wmask, resp_err} !== 9'b1_0_0_0000_00) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=100000000",
               {req_ready, mem_valid, resp_valid, mem_wmask, resp_err});
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_load_ext();
    mem_set(1'b1, 1'b1, 32'h80FF_FF00);
    exp_q.push_back({32'hFFFF_FF80, 5'd5, 2'd0});
    issue(1'b0, 2'd0, 1'b0, 32'h8000_0003, '0, 5'd5);
    @(negedge clk);
    checks++;
    if (!(mem_valid === 1'b1 && mem_addr === 32'h8000_0000 && mem_wen === 1'b0)) begin
      errors++;
      $display("FAIL lb_cycle1 got=v%b a=%h w=%b required=v1 a=80000000 w=0",
               mem_valid, mem_addr, mem_wen);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL lb_cycle2 got=%b required=1", resp_valid);
    end
    wait_idle();
    exp_q.push_back({32'h0000_0080, 5'd6, 2'd0});
    issue(1'b0, 2'd0, 1'b1, 32'h8000_0003, '0, 5'd6);
    wait_idle();
    exp_q.push_back({32'hFFFF_80FF, 5'd7, 2'd0});
    issue(1'b0, 2'd1, 1'b0, 32'h8000_0002, '0, 5'd7);
    wait_idle();
    exp_q.push_back({32'h0000_80FF, 5'd8, 2'd0});
    issue(1'b0, 2'd1, 1'b1, 32'h8000_0002, '0, 5'd8);
    wait_idle();
    exp_q.push_back({32'h80FF_FF00, 5'd9, 2'd0});
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0000, '0, 5'd9);
    wait_idle();
  endtask

  task automatic test_store_lanes();
    logic [31:0] a [3]  = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0004};
    logic [1:0]  s [3]  = '{2'd1, 2'd0, 2'd2};
    logic [31:0] wd [3] = '{32'h0000_1234, 32'h0000_00AB, 32'hCAFE_F00D};
    logic [31:0] ea [3] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0004};
    logic [31:0] ed [3] = '{32'h1234_0000, 32'h0000_AB00, 32'hCAFE_F00D};
    logic [3:0]  em [3] = '{4'b1100, 4'b0010, 4'b1111};
    mem_set(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({32'h0, 5'(10 + i), 2'd0});
      issue(1'b1, s[i], 1'b0, a[i], wd[i], 5'(10 + i));
      @(negedge clk);
      checks++;
      if (!(mem_valid === 1'b1 && mem_wen === 1'b1 && mem_addr === ea[i] &&
            mem_wmask === em[i] && mem_wdata === ed[i])) begin
        errors++;
        $display("FAIL store_lane%0d got=a%h m%b d%h required=a%h m%b d%h",
                 i, mem_addr, mem_wmask, mem_wdata, ea[i], em[i], ed[i]);
      end
      wait_idle();
    end
  endtask

  task automatic test_misalign();
    logic [31:0] a [3] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0000};
    logic [1:0]  s [3] = '{2'd2, 2'd1, 2'd3};
    mem_set(1'b1, 1'b1, 32'h5555_5555);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({32'h0, 5'(20 + i), 2'd1});
      issue(1'b0, s[i], 1'b0, a[i], '0, 5'(20 + i));
      @(negedge clk);
      checks++;
      if (!(mem_valid === 1'b0 && resp_valid === 1'b1 &&
            resp_err === 2'd1 && resp_rdata === 32'h0)) begin
        errors++;
        $display("FAIL misalign%0d got=mv%b rv%b e%0d d%h required=mv0 rv1 e1 d0",
                 i, mem_valid, resp_valid, resp_err, resp_rdata);
      end
      wait_idle();
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int at = -1;
    mem_set(1'b0, 1'b0, 32'h1111_1111);
    exp_q.push_back({32'h0, 5'd25, 2'd2});
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0010, '0, 5'd25);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        at = i;
        break;
      end
      if (mem_valid) n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (n !== 8 || at !== 8) begin
      errors++;
      $display("FAIL timeout_len got=mv%0d at%0d required=mv8 at8", n, at);
    end
    wait_idle();
    mem_set(1'b0, 1'b1, 32'h2222_2222);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_rvalid got=rv%b rr%b required=rv0 rr1",
                 resp_valid, req_ready);
      end
      @(posedge clk);
      #1;
    end
    mem_set(1'b0, 1'b0, '0);
  endtask

  task automatic test_backpressure();
    mem_set(1'b1, 1'b1, 32'h1357_9BDF);
    resp_ready = 1'b0;
    exp_q.push_back({32'h1357_9BDF, 5'd30, 2'd0});
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0008, '0, 5'd30);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (!(resp_valid === 1'b1 && resp_rdata === 32'h1357_9BDF &&
            resp_rd === 5'd30 && resp_err === 2'd0 && req_ready === 1'b0)) begin
        errors++;
        $display("FAIL hold%0d got=v%b d%h rd%0d rr%b required=v1 d13579bdf rd30 rr0",
                 i, resp_valid, resp_rdata, resp_rd, req_ready);
      end
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL release got=rr%b v%b required=rr1 v0", req_ready, resp_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    mem_set(1'b0, 1'b0, '0);
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0020, '0, 5'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mreq got=mv%b rv%b rr%b required=mv0 rv0 rr1",
               mem_valid, resp_valid, req_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    mem_set(1'b1, 1'b0, '0);
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0024, '0, 5'd2);
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || mem_valid !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mwait_state got=rr%b mv%b rv%b required=rr0 mv0 rv0",
               req_ready, mem_valid, resp_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mwait got=mv%b rv%b rr%b required=mv0 rv0 rr1",
               mem_valid, resp_valid, req_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    mem_set(1'b0, 1'b1, 32'h3333_3333);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL late_rvalid got=%b required=0", resp_valid);
      end
      @(posedge clk);
      #1;
    end
    mem_set(1'b1, 1'b0, 32'hDEAD_BEEF);
    exp_q.push_back({32'hDEAD_BEEF, 5'd3, 2'd0});
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0040, '0, 5'd3);
    @(posedge clk);
    #1;
    mem_rvalid = 1'b1;
    @(posedge clk);
    #1 mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_rst_resp got=%b required=1", resp_valid);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_store_lanes();
    test_misalign();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
